// File: rtl/data_path_if.sv
// Control/data bundle between the control unit (master) and the single-bus datapath (slave).
interface data_path_if;
    logic [31:0] Mdatain;
    logic [4:0]  ops;
    logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout;
    logic MDRout, MARout, PORTout, Cout;
    logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
    logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
    logic RAin, RYin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin, RZin;
    logic IncPC, Read, Write, gra, grb, grc, rin, rins, rout, routs, BAout;
    logic [31:0] BusMuxOut, MARq, MDRq, OutPort;
    logic        MemWrite;

    modport master (
        output Mdatain, ops,
        output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        output R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
        output RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout,
        output MDRout, MARout, PORTout, Cout,
        output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        output R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        output RAin, RYin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin, RZin,
        output IncPC, Read, Write, gra, grb, grc, rin, rins, rout, routs, BAout,
        input  BusMuxOut, MARq, MDRq, OutPort, MemWrite
    );

    modport slave (
        input  Mdatain, ops,
        input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
        input  R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
        input  RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout,
        input  MDRout, MARout, PORTout, Cout,
        input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
        input  R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
        input  RAin, RYin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin, RZin,
        input  IncPC, Read, Write, gra, grb, grc, rin, rins, rout, routs, BAout,
        output BusMuxOut, MARq, MDRq, OutPort, MemWrite
    );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus datapath: register file, special registers, ALU, select/encode, MDR/MAR.
// Optional mul/div enabled by defining DATAPATH_MULDIV_EN.
module data_path (
    input  logic         clock,
    input  logic         clear,
    data_path_if.slave   dp
);
    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
        OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000,
        OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011,
        OP_NEG  = 5'b01100, OP_NOT  = 5'b01101, OP_MUL  = 5'b01110,
        OP_DIV  = 5'b01111
    } alu_op_e;

    logic [31:0] r_q [16];
    logic [31:0] ra_q, y_q, pc_q, ir_q, hi_q, lo_q, mdr_q, mar_q, port_q;
    logic [63:0] z_q, z_d;
    logic [31:0] mdr_d, bus, c_val, r0_bus;
    logic [15:0] r_in_strb, r_out_strb, r_in_eff, r_out_eff, sel;
    logic [3:0]  field;
    logic [27:0] drv;
    logic [31:0] src [28];

    assign r_in_strb  = {dp.R15in, dp.R14in, dp.R13in, dp.R12in, dp.R11in, dp.R10in, dp.R9in, dp.R8in,
                         dp.R7in, dp.R6in, dp.R5in, dp.R4in, dp.R3in, dp.R2in, dp.R1in, dp.R0in};
    assign r_out_strb = {dp.R15out, dp.R14out, dp.R13out, dp.R12out, dp.R11out, dp.R10out, dp.R9out, dp.R8out,
                         dp.R7out, dp.R6out, dp.R5out, dp.R4out, dp.R3out, dp.R2out, dp.R1out, dp.R0out};

    assign field     = ({4{dp.gra}} & ir_q[26:23]) | ({4{dp.grb}} & ir_q[22:19]) | ({4{dp.grc}} & ir_q[18:15]);
    assign sel       = 16'h0001 << field;
    assign r_in_eff  = r_in_strb  | ({16{dp.rin | dp.rins}} & sel);
    assign r_out_eff = r_out_strb | ({16{dp.rout | dp.routs | dp.BAout}} & sel);
    // R0 reads as zero when it is selected only through BAout (base-address mode)
    assign r0_bus    = (dp.R0out | ((dp.rout | dp.routs) & sel[0])) ? r_q[0] : '0;
    assign c_val     = {{13{ir_q[18]}}, ir_q[18:0]};

    assign drv = {dp.Cout, dp.PORTout, dp.MARout, dp.MDRout, dp.LOout, dp.HIout, dp.IRout, dp.PCout,
                  dp.RZLOout, dp.RZHIout, dp.RYout, dp.RAout, r_out_eff};

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) src[i] = r_q[i];
        src[0]  = r0_bus;
        src[16] = ra_q;   src[17] = y_q;    src[18] = z_q[63:32]; src[19] = z_q[31:0];
        src[20] = pc_q;   src[21] = ir_q;   src[22] = hi_q;       src[23] = lo_q;
        src[24] = mdr_q;  src[25] = mar_q;  src[26] = port_q;     src[27] = c_val;
    end

    // Priority bus mux: the lowest-indexed asserted driver wins
    always_comb begin
        logic found;
        bus   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 28; i++) begin
            if (drv[i] && !found) begin
                bus   = src[i];
                found = 1'b1;
            end
        end
    end

    logic [31:0] a, b, sra_res;
    logic [63:0] ror_w, rol_w;
    assign a       = y_q;
    assign b       = bus;
    assign sra_res = $signed(a) >>> b[4:0];
    assign ror_w   = {a, a} >> b[4:0];
    assign rol_w   = {a, a} << b[4:0];
`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] mul_res;
    logic [31:0] quo, rem;
    assign mul_res = $signed(a) * $signed(b);
    assign quo     = $signed(a) / $signed(b);
    assign rem     = $signed(a) % $signed(b);
`endif

    always_comb begin
        z_d = '0;
        if (dp.IncPC) begin
            z_d = {32'd0, b + 32'd1};
        end else begin
            case (dp.ops)
                OP_ADD:  z_d = {32'd0, a + b};
                OP_SUB:  z_d = {32'd0, a - b};
                OP_AND:  z_d = {32'd0, a & b};
                OP_OR:   z_d = {32'd0, a | b};
                OP_SHR:  z_d = {32'd0, a >> b[4:0]};
                OP_SHRA: z_d = {32'd0, sra_res};
                OP_SHL:  z_d = {32'd0, a << b[4:0]};
                OP_ROR:  z_d = {32'd0, ror_w[31:0]};
                OP_ROL:  z_d = {32'd0, rol_w[63:32]};
                OP_NEG:  z_d = {32'd0, 32'd0 - b};
                OP_NOT:  z_d = {32'd0, ~b};
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  z_d = mul_res;
                OP_DIV:  if (b != '0) z_d = {rem, quo};
`endif
                default: z_d = '0;
            endcase
        end
    end

    assign mdr_d = dp.Read ? dp.Mdatain : bus;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
            ra_q <= '0; y_q <= '0; z_q <= '0; pc_q <= '0; ir_q <= '0;
            hi_q <= '0; lo_q <= '0; mdr_q <= '0; mar_q <= '0; port_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) if (r_in_eff[i]) r_q[i] <= bus;
            if (dp.RAin)   ra_q   <= bus;
            if (dp.RYin)   y_q    <= bus;
            if (dp.RZin)   z_q    <= z_d;
            if (dp.PCin)   pc_q   <= bus;
            if (dp.IRin)   ir_q   <= bus;
            if (dp.HIin)   hi_q   <= bus;
            if (dp.LOin)   lo_q   <= bus;
            if (dp.MDRin)  mdr_q  <= mdr_d;
            if (dp.MARin)  mar_q  <= bus;
            if (dp.PORTin) port_q <= bus;
        end
    end

    assign dp.BusMuxOut = bus;
    assign dp.MARq      = mar_q;
    assign dp.MDRq      = mdr_q;
    assign dp.OutPort   = port_q;
    assign dp.MemWrite  = dp.Write;
endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: expectations queued at stimulus time, checked as outputs appear.
module tb_data_path;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    data_path_if dpi ();
    data_path u_dut (.clock(clock), .clear(clear), .dp(dpi));

    always #5 clock = ~clock;

    typedef struct { string tag; logic [31:0] val; } exp_t;
    exp_t sbq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic idle();
        dpi.Mdatain = '0; dpi.ops = '0;
        {dpi.R0out, dpi.R1out, dpi.R2out, dpi.R3out, dpi.R4out, dpi.R5out, dpi.R6out, dpi.R7out} = '0;
        {dpi.R8out, dpi.R9out, dpi.R10out, dpi.R11out, dpi.R12out, dpi.R13out, dpi.R14out, dpi.R15out} = '0;
        {dpi.RAout, dpi.RYout, dpi.RZHIout, dpi.RZLOout, dpi.PCout, dpi.IRout, dpi.HIout, dpi.LOout} = '0;
        {dpi.MDRout, dpi.MARout, dpi.PORTout, dpi.Cout} = '0;
        {dpi.R0in, dpi.R1in, dpi.R2in, dpi.R3in, dpi.R4in, dpi.R5in, dpi.R6in, dpi.R7in} = '0;
        {dpi.R8in, dpi.R9in, dpi.R10in, dpi.R11in, dpi.R12in, dpi.R13in, dpi.R14in, dpi.R15in} = '0;
        {dpi.RAin, dpi.RYin, dpi.PCin, dpi.IRin, dpi.HIin, dpi.LOin, dpi.MDRin, dpi.MARin, dpi.PORTin, dpi.RZin} = '0;
        {dpi.IncPC, dpi.Read, dpi.Write, dpi.gra, dpi.grb, dpi.grc, dpi.rin, dpi.rins, dpi.rout, dpi.routs, dpi.BAout} = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_is(input string tag, input logic [31:0] v);
        expect_v(tag, v);
        #1;
        observe(dpi.BusMuxOut);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); dpi.Mdatain = v; dpi.Read = 1'b1; dpi.MDRin = 1'b1;
        step(); idle();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v); dpi.MDRout = 1'b1; dpi.RYin = 1'b1;
        step(); idle();
    endtask

    task automatic set_ir(input logic [31:0] v);
        load_mdr(v); dpi.MDRout = 1'b1; dpi.IRin = 1'b1;
        step(); idle();
    endtask

    // Writes a general register through the Ra field of IR (gra + rin)
    task automatic load_r(input logic [3:0] idx, input logic [31:0] v);
        set_ir({5'd0, idx, 23'd0});
        load_mdr(v); dpi.MDRout = 1'b1; dpi.gra = 1'b1; dpi.rin = 1'b1;
        step(); idle();
    endtask

    task automatic read_z(input string tag, input logic [63:0] zexp);
        idle(); dpi.RZLOout = 1'b1; bus_is({tag, "_zlo"}, zexp[31:0]);
        idle(); dpi.RZHIout = 1'b1; bus_is({tag, "_zhi"}, zexp[63:32]);
        idle();
    endtask

    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] zexp, input string tag);
        set_y(a);
        load_r(4'd3, b);
        dpi.R3out = 1'b1; dpi.ops = op; dpi.RZin = 1'b1;
        step();
        read_z(tag, zexp);
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        int ia, ib;
        logic [63:0] sa, sb;
        sh = int'(b[4:0]);
        r = a;
        ia = a; ib = b;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        model = '0;
        case (op)
            5'd3:  model = {32'd0, a + b};
            5'd4:  model = {32'd0, a - b};
            5'd5:  model = {32'd0, a & b};
            5'd6:  model = {32'd0, a | b};
            5'd7:  begin for (int k = 0; k < sh; k++) r = {1'b0, r[31:1]}; model = {32'd0, r}; end
            5'd8:  begin for (int k = 0; k < sh; k++) r = {r[31], r[31:1]}; model = {32'd0, r}; end
            5'd9:  begin for (int k = 0; k < sh; k++) r = {r[30:0], 1'b0}; model = {32'd0, r}; end
            5'd10: begin for (int k = 0; k < sh; k++) r = {r[0], r[31:1]}; model = {32'd0, r}; end
            5'd11: begin for (int k = 0; k < sh; k++) r = {r[30:0], r[31]}; model = {32'd0, r}; end
            5'd12: model = {32'd0, ~b + 32'd1};
            5'd13: model = {32'd0, ~b};
`ifdef DATAPATH_MULDIV_EN
            5'd14: model = sa * sb;
            5'd15: if (b != 32'd0) model = {32'(ia % ib), 32'(ia / ib)};
`endif
            default: model = '0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  op_list [15];
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic [63:0] mul_exp;
        op_list = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31};
        pa = '{32'h8000_00F3, 32'h1234_5678, 32'h0000_0050};
        pb = '{32'h0000_0024, 32'hFFFF_FFFD, 32'h0000_0000};

        idle();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        bus_is("rst_bus", 32'd0);
        expect_v("rst_mar", 32'd0);     observe(dpi.MARq);
        expect_v("rst_mdr", 32'd0);     observe(dpi.MDRq);
        expect_v("rst_port", 32'd0);    observe(dpi.OutPort);
        expect_v("rst_memwr", 32'd0);   observe({31'd0, dpi.MemWrite});
        clear = 1'b1;

        // Instruction fetch/decode walk-through
        dpi.PCout = 1'b1; dpi.IncPC = 1'b1; dpi.RZin = 1'b1;
        step(); idle();
        dpi.RZLOout = 1'b1; dpi.PCin = 1'b1;
        bus_is("zlo_incpc", 32'd1);
        step(); idle();
        dpi.PCout = 1'b1; bus_is("pc_after_inc", 32'd1);
        load_mdr(32'h0090_0045);
        expect_v("mdr_read", 32'h0090_0045); observe(dpi.MDRq);
        dpi.MDRout = 1'b1; dpi.IRin = 1'b1;
        step(); idle();
        dpi.IRout = 1'b1; bus_is("ir_load", 32'h0090_0045); idle();
        dpi.grb = 1'b1; dpi.BAout = 1'b1; dpi.RYin = 1'b1;
        step(); idle();
        dpi.Cout = 1'b1; dpi.ops = 5'b00011; dpi.RZin = 1'b1;
        bus_is("c_field", 32'h0000_0045);
        step(); idle();
        dpi.RZLOout = 1'b1; dpi.MARin = 1'b1;
        step(); idle();
        expect_v("mar_load", 32'h0000_0045); observe(dpi.MARq);
        load_mdr(32'h0000_1234);
        dpi.MDRout = 1'b1; dpi.gra = 1'b1; dpi.rin = 1'b1;
        step(); idle();
        dpi.R1out = 1'b1; bus_is("r1_load", 32'h0000_1234); idle();

        dpi.Write = 1'b1; expect_v("memwrite", 32'd1); #1; observe({31'd0, dpi.MemWrite}); idle();

        set_ir(32'h0004_0001);
        dpi.Cout = 1'b1; bus_is("c_signext", 32'hFFFC_0001); idle();

        alu_run(5'b00100, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE, "sub");
`ifdef DATAPATH_MULDIV_EN
        mul_exp = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        mul_exp = 64'd0;
`endif
        alu_run(5'b01110, 32'hFFFF_FFFF, 32'd2, mul_exp, "mul");

        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 15; k++) begin
                alu_run(op_list[k], pa[p], pb[p], model(op_list[k], pa[p], pb[p]),
                        $sformatf("alu_p%0d_op%0d", p, op_list[k]));
            end
        end

        // Base-address mode on R0
        load_r(4'd0, 32'h0000_0099);
        dpi.grb = 1'b1; dpi.BAout = 1'b1; bus_is("ba_r0_zero", 32'd0); idle();
        dpi.R0out = 1'b1; bus_is("r0out", 32'h0000_0099); idle();
        dpi.grb = 1'b1; dpi.rout = 1'b1; bus_is("rout_r0", 32'h0000_0099); idle();

        bus_is("no_driver", 32'd0);
        load_r(4'd2, 32'h0000_00AA);
        load_r(4'd5, 32'h0000_0055);
        dpi.R2out = 1'b1; dpi.R5out = 1'b1; bus_is("bus_priority", 32'h0000_00AA); idle();
        dpi.R5out = 1'b1; dpi.PORTin = 1'b1;
        step(); idle();
        expect_v("outport", 32'h0000_0055); observe(dpi.OutPort);

        // Same-cycle drive and load: old value on bus, new value after edge
        load_mdr(32'h0000_0111);
        dpi.MDRout = 1'b1; dpi.MDRin = 1'b1; dpi.Read = 1'b1; dpi.Mdatain = 32'h0000_0222;
        bus_is("mdr_old_on_bus", 32'h0000_0111);
        step(); idle();
        expect_v("mdr_new", 32'h0000_0222); observe(dpi.MDRq);

        // Asynchronous clear between edges
        load_mdr(32'd7);
        dpi.MDRout = 1'b1; dpi.PCin = 1'b1; dpi.MARin = 1'b1;
        step(); idle();
        dpi.PCout = 1'b1; dpi.IncPC = 1'b1; dpi.RZin = 1'b1;
        step(); idle();
        dpi.PCout = 1'b1; bus_is("pc_before_clr", 32'd7);
        clear = 1'b0;
        bus_is("pc_async_clr", 32'd0);
        expect_v("mar_async_clr", 32'd0); observe(dpi.MARq);
        idle(); dpi.RZLOout = 1'b1; bus_is("zlo_async_clr", 32'd0); idle();
        #1 clear = 1'b1;
        step();
        dpi.PCout = 1'b1; bus_is("pc_after_clr", 32'd0); idle();

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_path.md
# data_path

32-bit single-bus CPU datapath: register file, special registers, ALU, select-and-encode logic and memory interface registers around one shared bus. It sits below the control unit, which sequences it through per-cycle strobes. Main memory is external: MAR is exported and read data enters on Mdatain.

## Interface
No parameters.
- clock  in  1  single clock; all registers load on rising edge
- clear  in  1  asynchronous, active-low reset (0 = reset)
- Mdatain  in  32  memory read data
- ops  in  5  ALU operation select
- R0out..R15out, RAout, RYout, RZHIout, RZLOout, PCout, IRout, HIout, LOout, MDRout, MARout, PORTout  in  1 each  drive that register onto bus
- Cout  in  1  drive sign-extended IR[18:0] onto bus
- R0in..R15in, RAin, RYin, PCin, IRin, HIin, LOin, MDRin, MARin, PORTin  in  1 each  load that register from bus
- RZin  in  1  load 64-bit Z from ALU
- IncPC  in  1  ALU computes bus+1, overriding ops
- Read  in  1  MDR source = Mdatain (else bus)
- Write  in  1  memory write strobe, passed to MemWrite
- gra, grb, grc  in  1 each  select Ra/Rb/Rc field of IR
- rin, rins  in  1 each  load selected register
- rout, routs  in  1 each  drive selected register
- BAout  in  1  drive selected register; R0 reads as 0
- BusMuxOut  out  32  current bus value
- MARq  out  32  MAR contents (memory address)
- MDRq  out  32  MDR contents (write data)
- OutPort  out  32  PORT register contents
- MemWrite  out  1  = Write

## Operation
- Registers, 32-bit unless noted: R0–R15, RA, Y, Z (64-bit, ZHI=Z[63:32], ZLO=Z[31:0]), PC, IR, HI, LO, MDR, MAR, PORT.
- Select-and-encode: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]; sel = OR of gra·Ra, grb·Rb, grc·Rc, decoded one-hot. Effective Ri load = Riin | ((rin|rins) & sel_i); Ri drive = Riout | ((rout|routs|BAout) & sel_i).
- BAout with R0 selected drives 0; R0out or rout on R0 drives R0 contents.
- C = sign-extend IR[18:0] to 32 bits.
- Bus: combinational mux. One driver is expected; if several assert, priority R0..R15, RA, Y, ZHI, ZLO, PC, IR, HI, LO, MDR, MAR, PORT, C (lowest index wins). With no driver, bus = 0.
- MDR loads Read ? Mdatain : bus when MDRin=1.
- ALU: A=Y, B=bus, result 64-bit into Z when RZin. For 32-bit results, Z[63:32]=0.
- Ops: 00011 add; 00100 sub (A−B); 00101 and; 00110 or; 00111 shr (logical, B[4:0]); 01000 shra; 01001 shl; 01010 ror; 01011 rol; 01100 neg (−B); 01101 not (~B); 01110 mul (signed A×B, full 64-bit); 01111 div (ZLO=A/B quotient, ZHI=A%B remainder, signed).
- Other codes give Z=0. IncPC=1 gives Z={32'b0, B+1}.
- Add/sub wrap modulo 2^32; no flags.

## Timing
- All loads occur on the rising clock edge where the strobe is high. Bus and ALU are combinational within the cycle.
- Single-cycle latency: a value driven in cycle n is visible from a register in cycle n+1.
- Reset (clear=0) at any time immediately zeroes every register, including mid-sequence. Outputs read 0 and bus reads 0 with no driver; loads are ignored while clear=0.
- Simultaneous load and drive of the same register: the old value drives the bus, the new value loads at the edge.
- Div by zero: Z=0.

## Configuration
- DATAPATH_MULDIV_EN: when defined, mul (01110) and div (01111) are implemented as above. When undefined, those codes behave as unlisted codes (Z=0), and no multiplier or divider is synthesized.

## Test plan
- Load sequence:
  - Reset, then PCout+IncPC+RZin → ZLO=1. ZLO→PCin → PC=1.
  - Mdatain=0x00900045, Read+MDRin, then MDRout+IRin → IR=0x00900045.
  - grb+BAout+RYin, then Cout+ops=00011+RZin → ZLO=0x45; ZLO→MARin → MARq=0x45.
  - Mdatain=0x1234, Read+MDRin; MDRout+gra+rin → R1=0x1234.
- ALU: Y=5, bus=7 (R3), ops=00100 → ZLO=0xFFFFFFFE, ZHI=0.
- Mul (macro defined): Y=0xFFFFFFFF, bus=2, ops=01110 → ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFE. Macro undefined → Z=0.
- Base address: R0=0x99, IR Rb=0, grb+BAout → bus=0. R0out → bus=0x99.
- Bus: no out strobe → BusMuxOut=0. R2out+R5out both high → R2 value on bus.
- Async reset: pull clear low mid-clock after PC=7 → PC, Z, MAR read 0 immediately, before the next edge.
